// File: rtl/stream_unpack_pkg.sv
// Shared types and helpers for the stream_unpack block.
// Optional feature macro: STREAM_UNPACK_SHORT_EN (early word termination on in_last).
package stream_unpack_pkg;

  // Controller states: gather slices, then present the finished word.
  typedef enum logic {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } state_e;

  // Width of a counter that runs 0..n-1.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/stream_unpack_ctrl.sv
// Handshake FSM and slice counter for stream_unpack.
// Optional feature macro: STREAM_UNPACK_SHORT_EN adds in_last early termination.
module stream_unpack_ctrl
  import stream_unpack_pkg::*;
#(
  parameter int unsigned N    = 4,
  parameter int unsigned CntW = cnt_width(N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  input  logic            out_ready,
`ifdef STREAM_UNPACK_SHORT_EN
  input  logic            in_last,
  output logic            out_short,
`endif
  output logic            in_ready,
  output logic            in_xfer,
  output logic            out_valid,
  output logic [CntW-1:0] cnt
);

  state_e          state_q;
  logic [CntW-1:0] cnt_q;
  logic            last_slot;
  logic            word_end;
`ifdef STREAM_UNPACK_SHORT_EN
  logic            early;
  logic            short_q;
`endif

  // cnt is always 0 in HOLD, so a slice taken there is slot 0 of the next word.
  assign last_slot = (cnt_q == CntW'(N - 1));
`ifdef STREAM_UNPACK_SHORT_EN
  assign early     = in_last & ~last_slot;
  assign word_end  = last_slot | early;
  assign out_short = short_q;
`else
  assign word_end  = last_slot;
`endif

  // Reset blocks acceptance so a discarded word cannot be refilled in the same cycle.
  assign in_ready  = ~rst & ((state_q == COLLECT) | out_ready);
  assign in_xfer   = in_valid & in_ready;
  assign out_valid = (state_q == HOLD);
  assign cnt       = cnt_q;

  // State, counter and short flag; any accepted slice decides the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= COLLECT;
      cnt_q   <= '0;
`ifdef STREAM_UNPACK_SHORT_EN
      short_q <= 1'b0;
`endif
    end else if (in_xfer) begin
      if (word_end) begin
        state_q <= HOLD;
        cnt_q   <= '0;
`ifdef STREAM_UNPACK_SHORT_EN
        short_q <= early;
`endif
      end else begin
        state_q <= COLLECT;
        cnt_q   <= cnt_q + 1'b1;
      end
    end else if ((state_q == HOLD) && out_ready) begin
      state_q <= COLLECT;
    end
  end

endmodule

// File: rtl/stream_unpack.sv
// Slice-to-word unpacker: reassembles SLICE_W-bit slices into WORD_W-bit words.
// Optional feature macro: STREAM_UNPACK_SHORT_EN enables in_last early termination
// with zero padding and out_short; without it in_last is ignored and out_short is 0.
module stream_unpack
  import stream_unpack_pkg::*;
#(
  parameter int unsigned WORD_W  = 16,
  parameter int unsigned SLICE_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [SLICE_W-1:0] in_slice,
  input  logic               in_last,
  input  logic               rev_order,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WORD_W-1:0]  out_word,
  output logic               out_short
);

  localparam int unsigned N    = WORD_W / SLICE_W;
  localparam int unsigned CntW = cnt_width(N);

  logic              in_xfer;
  logic [CntW-1:0]   cnt;
  logic              first;
  logic              rev_use;
  logic              rev_q;
  int unsigned       idx;
  logic [WORD_W-1:0] word_q;
  logic [WORD_W-1:0] word_d;

  stream_unpack_ctrl #(
    .N    (N),
    .CntW (CntW)
  ) u_ctrl (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .out_ready (out_ready),
`ifdef STREAM_UNPACK_SHORT_EN
    .in_last   (in_last),
    .out_short (out_short),
`endif
    .in_ready  (in_ready),
    .in_xfer   (in_xfer),
    .out_valid (out_valid),
    .cnt       (cnt)
  );

`ifndef STREAM_UNPACK_SHORT_EN
  logic unused_in_last;
  assign unused_in_last = in_last;
  assign out_short      = 1'b0;
`endif

  assign first    = (cnt == '0);
  assign out_word = word_q;

  // Place the incoming slice; slot 0 starts from a cleared word so gaps read as 0.
  always_comb begin
    rev_use = first ? rev_order : rev_q;
    idx     = rev_use ? int'(cnt) : (N - 1 - int'(cnt));
    word_d  = first ? '0 : word_q;
    word_d[idx*SLICE_W +: SLICE_W] = in_slice;
  end

  // Assembly register and per-word order latch.
  always_ff @(posedge clk) begin
    if (rst) begin
      word_q <= '0;
      rev_q  <= 1'b0;
    end else if (in_xfer) begin
      word_q <= word_d;
      if (first) rev_q <= rev_order;
    end
  end

endmodule

// File: tb/tb_stream_unpack.sv
// Directed self-checking bench for stream_unpack (16/4 and 8/2 instances).
module tb_stream_unpack;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_slice;
  logic        in_last;
  logic        rev_order;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_word;
  logic        out_short;

  logic        b_rst;
  logic        b_in_valid;
  logic        b_in_ready;
  logic [1:0]  b_in_slice;
  logic        b_in_last;
  logic        b_rev_order;
  logic        b_out_valid;
  logic        b_out_ready;
  logic [7:0]  b_out_word;
  logic        b_out_short;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  stream_unpack #(.WORD_W(16), .SLICE_W(4)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_slice  (in_slice),
    .in_last   (in_last),
    .rev_order (rev_order),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_word  (out_word),
    .out_short (out_short)
  );

  stream_unpack #(.WORD_W(8), .SLICE_W(2)) u_dut8 (
    .clk       (clk),
    .rst       (b_rst),
    .in_valid  (b_in_valid),
    .in_ready  (b_in_ready),
    .in_slice  (b_in_slice),
    .in_last   (b_in_last),
    .rev_order (b_rev_order),
    .out_valid (b_out_valid),
    .out_ready (b_out_ready),
    .out_word  (b_out_word),
    .out_short (b_out_short)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Offer one slice for one cycle with the main instance, then drop valid.
  task automatic send(input logic [3:0] s, input logic last);
    in_valid = 1'b1;
    in_slice = s;
    in_last  = last;
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic send8(input logic [1:0] s);
    b_in_valid = 1'b1;
    b_in_slice = s;
    tick();
    b_in_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_slice = '0; in_last = 1'b0;
    rev_order = 1'b0; out_ready = 1'b0;
    b_rst = 1'b1; b_in_valid = 1'b0; b_in_slice = '0; b_in_last = 1'b0;
    b_rev_order = 1'b0; b_out_ready = 1'b1;
    tick();
    tick();

    // Reset state
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_word", out_word, 16'h0000);
    chk("rst_out_short", out_short, 0);
    rst = 1'b0; b_rst = 1'b0; out_ready = 1'b1;
    #1;
    chk("idle_in_ready", in_ready, 1);

    // MSB-first word
    send(4'h1, 0); send(4'h2, 0); send(4'h3, 0);
    chk("msb_no_early_valid", out_valid, 0);
    send(4'h4, 0);
    chk("msb_valid", out_valid, 1);
    chk("msb_word", out_word, 16'h1234);
    chk("msb_short", out_short, 0);
    tick();
    chk("msb_consumed", out_valid, 0);

    // LSB-first word
    rev_order = 1'b1;
    send(4'h1, 0); send(4'h2, 0); send(4'h3, 0); send(4'h4, 0);
    chk("lsb_word", out_word, 16'h4321);
    chk("lsb_valid", out_valid, 1);
    tick();
    rev_order = 1'b0;

    // Back-to-back words at one slice per cycle
    in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_slice = 4'(9 + i);
      #1;
      chk("b2b_in_ready", in_ready, 1);
      tick();
      if (i == 3) chk("b2b_word0", out_word, 16'h9ABC);
      if (i == 4) chk("b2b_drop", out_valid, 0);
    end
    in_valid = 1'b0;
    chk("b2b_valid1", out_valid, 1);
    chk("b2b_word1", out_word, 16'hDEF0);
    tick();
    chk("b2b_consumed", out_valid, 0);

    // Stall in HOLD, with rev_order flipped mid-word
    out_ready = 1'b0;
    send(4'h1, 0);
    rev_order = 1'b1;
    send(4'h2, 0); send(4'h3, 0); send(4'h4, 0);
    in_valid = 1'b1; in_slice = 4'h7;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("stall_in_ready", in_ready, 0);
      chk("stall_valid", out_valid, 1);
      chk("stall_word", out_word, 16'h1234);
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1; rev_order = 1'b0;
    tick();
    chk("stall_emitted_once", out_valid, 0);

    // in_last handling
    send(4'hA, 0);
    send(4'hB, 1);
`ifdef STREAM_UNPACK_SHORT_EN
    chk("short_valid", out_valid, 1);
    chk("short_word", out_word, 16'hAB00);
    chk("short_flag", out_short, 1);
    tick();
    rev_order = 1'b1;
    send(4'hA, 0);
    send(4'hB, 1);
    chk("short_rev_word", out_word, 16'h00BA);
    chk("short_rev_flag", out_short, 1);
    tick();
    rev_order = 1'b0;
`else
    chk("nolast_no_valid", out_valid, 0);
    send(4'hC, 0);
    send(4'hD, 0);
    chk("nolast_word", out_word, 16'hABCD);
    chk("nolast_short", out_short, 0);
    tick();
`endif

    // Reset mid-word discards the partial word
    send(4'h1, 0); send(4'h2, 0);
    rst = 1'b1; in_valid = 1'b1; in_slice = 4'h3;
    #1;
    chk("rst_blocks_ready", in_ready, 0);
    tick();
    rst = 1'b0; in_valid = 1'b0;
    chk("rst_mid_valid", out_valid, 0);
    send(4'h5, 0); send(4'h6, 0); send(4'h7, 0);
    chk("rst_no_partial", out_valid, 0);
    send(4'h8, 0);
    chk("rst_after_word", out_word, 16'h5678);
    chk("rst_after_valid", out_valid, 1);
    tick();

    // 8-bit word, 2-bit slices
    send8(2'b01); send8(2'b10); send8(2'b11); send8(2'b00);
    chk("w8_msb_word", b_out_word, 8'h6C);
    chk("w8_msb_valid", b_out_valid, 1);
    tick();
    b_rev_order = 1'b1;
    send8(2'b01); send8(2'b10); send8(2'b11); send8(2'b00);
    chk("w8_lsb_word", b_out_word, 8'h39);
    chk("w8_lsb_short", b_out_short, 0);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
